// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding memory request, stall/flush handling, IF_ID word register.
// Optional INST_FETCH_ALIGN_CHECK_EN adds a misaligned-redirect FAULT state and o_fault.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_memReq,
    output logic [31:0] o_memAddr,
    input  logic        i_memReady,
    input  logic        i_memValid,
    input  logic [31:0] i_memData,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_flushPc,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_fault
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
`ifdef INST_FETCH_ALIGN_CHECK_EN
        StFault,
`endif
        StDrop
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst;
    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_flush_pc;
    logic        w_flush_bad;
    state_t      w_flush_dst;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic r_fault, w_fault_nxt;
    assign w_flush_pc  = i_flushPc;
    assign w_flush_bad = i_flush && (i_flushPc[1:0] != 2'b00);
    assign w_flush_dst = w_flush_bad ? StFault : StReq;
    assign o_fault     = r_fault;
`else
    assign w_flush_pc  = i_flushPc & 32'hFFFF_FFFC;
    assign w_flush_bad = 1'b0;
    assign w_flush_dst = StReq;
    assign o_fault     = 1'b0;
`endif

    // A new request may go out only if the held word is absent or leaves this edge.
    assign o_memReq  = (r_state == StReq) && (!r_valid || !i_stall);
    assign o_memAddr = o_memReq ? r_pc : 32'h0;
    assign w_accept  = o_memReq && i_memReady;
    assign w_capture = (r_state == StWait) && i_memValid && !i_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        w_fault_nxt = r_fault;
        if (i_flush) w_fault_nxt = w_flush_bad;
`endif
        if (i_flush) w_pc_nxt = w_flush_pc;
        unique case (r_state)
            StIdle: w_state_nxt = i_flush ? w_flush_dst : StReq;
            StReq: begin
                if (i_flush)       w_state_nxt = w_accept ? StDrop : w_flush_dst;
                else if (w_accept) w_state_nxt = StWait;
            end
            StWait: begin
                if (i_flush) begin
                    w_state_nxt = i_memValid ? w_flush_dst : StDrop;
                end else if (i_memValid) begin
                    w_state_nxt = StReq;
                    w_pc_nxt    = r_pc + 32'd4;
                end
            end
            StDrop: begin
                if (i_memValid) begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
                    w_state_nxt = w_fault_nxt ? StFault : StReq;
`else
                    w_state_nxt = StReq;
`endif
                end
            end
`ifdef INST_FETCH_ALIGN_CHECK_EN
            StFault: if (i_flush && !w_flush_bad) w_state_nxt = StReq;
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_pc_out <= 32'h0;
            r_inst   <= 32'h0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            r_fault  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            r_fault <= w_fault_nxt;
`endif
            if (i_flush) begin
                r_valid <= 1'b0;
                r_inst  <= 32'h0;
            end else if (w_capture) begin
                r_valid  <= 1'b1;
                r_pc_out <= r_pc;
                r_inst   <= i_memData;
            end else if (r_valid && !i_stall) begin
                r_valid <= 1'b0;
                r_inst  <= 32'h0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc_out;
    assign o_inst  = r_inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; memory handshakes are driven by hand.
// Fault expectations switch with INST_FETCH_ALIGN_CHECK_EN.
module tb_inst_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_memReq;
    logic [31:0] o_memAddr;
    logic        i_memReady;
    logic        i_memValid;
    logic [31:0] i_memData;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_flushPc;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_fault;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_memReq   (o_memReq),
        .o_memAddr  (o_memAddr),
        .i_memReady (i_memReady),
        .i_memValid (i_memValid),
        .i_memData  (i_memData),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_flushPc  (i_flushPc),
        .o_valid    (o_valid),
        .o_pc       (o_pc),
        .o_inst     (o_inst),
        .o_fault    (o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let outputs settle before the next drive/check.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rst = 1'b0; i_memReady = 1'b0; i_memValid = 1'b0; i_memData = 32'h0;
        i_stall = 1'b0; i_flush = 1'b0; i_flushPc = 32'h0;
    endtask

    initial begin
        idle_inputs();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_req", {31'b0, o_memReq}, 32'h0);
        check("rst_addr", o_memAddr, 32'h0);
        check("rst_fault", {31'b0, o_fault}, 32'h0);

        // First fetch: accept immediately, data two cycles later
        cyc();
        i_memReady = 1'b1; #1;
        check("f0_req", {31'b0, o_memReq}, 32'h1);
        check("f0_addr", o_memAddr, 32'h0);
        cyc();
        i_memReady = 1'b0;
        cyc();
        i_memValid = 1'b1; i_memData = 32'h3421_00FF; #1;
        check("f0_notyet", {31'b0, o_valid}, 32'h0);
        cyc();
        i_memValid = 1'b0; i_memData = 32'h0; #1;
        check("f0_valid", {31'b0, o_valid}, 32'h1);
        check("f0_pc", o_pc, 32'h0);
        check("f0_inst", o_inst, 32'h3421_00FF);
        check("f1_req", {31'b0, o_memReq}, 32'h1);
        check("f1_addr", o_memAddr, 32'h4);

        // Stall five cycles: no request, outputs frozen
        i_stall = 1'b1; i_memReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stl_req", {31'b0, o_memReq}, 32'h0);
            check("stl_valid", {31'b0, o_valid}, 32'h1);
            check("stl_inst", o_inst, 32'h3421_00FF);
            check("stl_pc", o_pc, 32'h0);
            cyc();
        end
        i_stall = 1'b0; #1;
        check("unstl_req", {31'b0, o_memReq}, 32'h1);
        check("unstl_addr", o_memAddr, 32'h4);
        cyc();
        i_memReady = 1'b0; #1;
        check("cons_valid", {31'b0, o_valid}, 32'h0);
        check("cons_inst", o_inst, 32'h0);

        // Flush while waiting: returning word dropped
        i_flush = 1'b1; i_flushPc = 32'h0000_0100;
        cyc();
        i_flush = 1'b0; #1;
        check("drop_req", {31'b0, o_memReq}, 32'h0);
        i_memValid = 1'b1; i_memData = 32'hDEAD_BEEF;
        cyc();
        i_memValid = 1'b0; #1;
        check("drop_valid", {31'b0, o_valid}, 32'h0);
        check("drop_inst", o_inst, 32'h0);
        check("drop_addr", o_memAddr, 32'h0000_0100);

        // Flush on the same edge as the response
        i_memReady = 1'b1;
        cyc();
        i_memReady = 1'b0;
        i_memValid = 1'b1; i_memData = 32'h1111_1111; i_flush = 1'b1; i_flushPc = 32'h0000_0200;
        cyc();
        i_memValid = 1'b0; i_flush = 1'b0; #1;
        check("coin_valid", {31'b0, o_valid}, 32'h0);
        check("coin_inst", o_inst, 32'h0);
        check("coin_addr", o_memAddr, 32'h0000_0200);

        // Flush on the accepting edge goes through DROP
        i_memReady = 1'b1; i_flush = 1'b1; i_flushPc = 32'hFFFF_FFFC;
        cyc();
        i_memReady = 1'b0; i_flush = 1'b0; #1;
        check("acc_fl_req", {31'b0, o_memReq}, 32'h0);
        i_memValid = 1'b1; i_memData = 32'h2222_2222;
        cyc();
        i_memValid = 1'b0; #1;
        check("acc_fl_valid", {31'b0, o_valid}, 32'h0);
        check("acc_fl_addr", o_memAddr, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space
        i_memReady = 1'b1;
        cyc();
        i_memReady = 1'b0;
        i_memValid = 1'b1; i_memData = 32'hCAFE_F00D;
        cyc();
        i_memValid = 1'b0; #1;
        check("wrap_pc", o_pc, 32'hFFFF_FFFC);
        check("wrap_inst", o_inst, 32'hCAFE_F00D);
        check("wrap_addr", o_memAddr, 32'h0);
        cyc();
        check("wrap_cons", {31'b0, o_valid}, 32'h0);

        // Misaligned redirect
        i_flush = 1'b1; i_flushPc = 32'h0000_0303;
        cyc();
        i_flush = 1'b0; #1;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, o_fault}, 32'h1);
        check("mis_req", {31'b0, o_memReq}, 32'h0);
        i_flushPc = 32'h0000_0102; i_flush = 1'b1;
        cyc();
        i_flush = 1'b0; #1;
        check("mis2_fault", {31'b0, o_fault}, 32'h1);
        check("mis2_req", {31'b0, o_memReq}, 32'h0);
`else
        check("mis_fault", {31'b0, o_fault}, 32'h0);
        check("mis_addr", o_memAddr, 32'h0000_0300);
`endif
        i_flush = 1'b1; i_flushPc = 32'h0000_0200;
        cyc();
        i_flush = 1'b0; #1;
        check("al_fault", {31'b0, o_fault}, 32'h0);
        check("al_req", {31'b0, o_memReq}, 32'h1);
        check("al_addr", o_memAddr, 32'h0000_0200);

        // Reset beats flush and response; late response ignored
        i_memReady = 1'b1;
        cyc();
        i_memReady = 1'b0;
        i_rst = 1'b1; i_memValid = 1'b1; i_memData = 32'h3333_3333; i_flush = 1'b1;
        i_flushPc = 32'h0000_0400;
        cyc();
        i_rst = 1'b0; i_flush = 1'b0; #1;
        check("rp_req", {31'b0, o_memReq}, 32'h0);
        check("rp_valid", {31'b0, o_valid}, 32'h0);
        cyc();
        i_memValid = 1'b0; #1;
        check("rp_late_valid", {31'b0, o_valid}, 32'h0);
        check("rp_addr", o_memAddr, 32'h0);
        check("rp_req2", {31'b0, o_memReq}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
